// File: rtl/hamming_rx_deser.sv
// hamming_rx_deser: serial Hamming(7,4) receiver that deserialises, corrects single-bit errors
// and presents the data nibble on a valid/ready port with saturating frame statistics.
module hamming_rx_deser #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin_valid,
    input  logic             sin_bit,
    input  logic             sin_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_corrected,
    output logic [2:0]       out_syndrome,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] corr_count,
    output logic             overflow
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           r_state, w_state_nx;
    logic [2:0]       r_cnt, w_cnt_nx;
    logic [6:0]       r_sr, w_sr_nx;
    logic             w_complete;
    logic [6:0]       r_dec;
    logic             r_dec_v;
    logic             r_out_valid;
    logic [3:0]       r_out_data;
    logic             r_out_corr;
    logic [2:0]       r_out_syn;
    logic [CNT_W-1:0] r_fc, r_cc;
    logic             r_ovf;
    logic [2:0]       w_syn;
    logic [6:0]       w_fix;
    logic             w_load;
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_sr_nx    = r_sr;
        w_complete = 1'b0;
        if (sin_valid) begin
            if (sin_start) begin
                w_sr_nx[0] = sin_bit;
                w_cnt_nx   = 3'd1;
                w_state_nx = SHIFT;
            end else if (r_state == SHIFT) begin
                w_sr_nx[r_cnt] = sin_bit;
                w_complete     = (r_cnt == 3'd6);
                w_state_nx     = w_complete ? IDLE : SHIFT;
                w_cnt_nx       = w_complete ? 3'd0 : r_cnt + 3'd1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_sr    <= 7'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_sr    <= w_sr_nx;
        end
    end
    // Codeword index i holds Hamming position i+1, so syndrome s flips index s-1.
    assign w_syn  = {r_dec[3] ^ r_dec[4] ^ r_dec[5] ^ r_dec[6],
                     r_dec[1] ^ r_dec[2] ^ r_dec[5] ^ r_dec[6],
                     r_dec[0] ^ r_dec[2] ^ r_dec[4] ^ r_dec[6]};
    assign w_fix  = r_dec ^ ((w_syn != 3'd0) ? (7'd1 << (w_syn - 3'd1)) : 7'd0);
    assign w_load = r_dec_v && (!r_out_valid || out_ready);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec       <= 7'd0;
            r_dec_v     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 4'd0;
            r_out_corr  <= 1'b0;
            r_out_syn   <= 3'd0;
            r_fc        <= '0;
            r_cc        <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_dec_v <= w_complete;
            if (w_complete)
                r_dec <= w_sr_nx;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= {w_fix[6], w_fix[5], w_fix[4], w_fix[2]};
                r_out_corr  <= (w_syn != 3'd0);
                r_out_syn   <= w_syn;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (clr_stats) begin
                r_fc  <= '0;
                r_cc  <= '0;
                r_ovf <= 1'b0;
            end else if (r_dec_v) begin
                if (r_fc != '1)
                    r_fc <= r_fc + CNT_W'(1);
                if (w_syn != 3'd0 && r_cc != '1)
                    r_cc <= r_cc + CNT_W'(1);
                if (!w_load)
                    r_ovf <= 1'b1;
            end
        end
    end
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_corrected = r_out_corr;
    assign out_syndrome  = r_out_syn;
    assign frame_count   = r_fc;
    assign corr_count    = r_cc;
    assign overflow      = r_ovf;
endmodule
